ex_mem_reg: RTL and testbench

- EX/MEM pipeline register: captures EX-stage results and controls each cycle and presents them to the MEM stage (data-memory address, store data, control bits, MEMop).
- Adds stall/flush handling, bubble insertion, store byte-lane steering with byte enables, and misaligned-access suppression with a saturating event counter.
- Drives an ALU-result forwarding port back to EX.

---
 rtl/ex_mem_reg.sv | 226 ++++++++++++++++++++++
 tb/tb_ex_mem_reg.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: stall/flush/bubble handling, store lane
// steering with byte enables, misaligned-access suppression and counting.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid              EX holds a real instruction (0 = bubble)
//   ex_alu_result         ALU result / effective address
//   ex_store_data         rs2 value for stores
//   ex_rd                 destination register
//   ex_reg_write          register-file write request
//   ex_mem_read           load
//   ex_mem_write          store
//   ex_mem_to_reg         writeback selects memory data
//   ex_mem_op             000 word, 001 lb, 010 lh, 011 lbu, 100 lhu
//   stall, flush          hold / kill (flush wins)
//   mem_valid             MEM holds a real instruction
//   mem_address           registered ALU result
//   mem_write_data        lane-steered store data
//   mem_byte_en           store byte enables
//   mem_read, mem_write,
//   mem_to_reg            qualified memory controls
//   mem_op, mem_rd        registered MEMop and destination
//   mem_reg_write         qualified register-write enable
//   misalign              MEM instruction was a suppressed misaligned access
//   misalign_cnt          saturating misaligned-access count
//   fwd_valid, fwd_rd,
//   fwd_data              ALU-result forwarding port back to EX

module ex_mem_reg #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_alu_result,
    input  logic [ADDR_W-1:0] ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic [2:0]        ex_mem_op,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [ADDR_W-1:0] mem_write_data,
    output logic [3:0]        mem_byte_en,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic [2:0]        mem_op,
    output logic [4:0]        mem_rd,
    output logic              mem_reg_write,
    output logic              misalign,
    output logic [CNT_W-1:0]  misalign_cnt,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [ADDR_W-1:0] fwd_data
);

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_B  = 3'b001;
    localparam logic [2:0] OP_H  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b011;
    localparam logic [2:0] OP_HU = 3'b100;

    localparam int NBYTES = ADDR_W / 8;

    // Registered state
    logic              valid_q,   valid_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [ADDR_W-1:0] wdata_q,   wdata_d;
    logic [3:0]        be_q,      be_d;
    logic              rd_en_q,   rd_en_d;
    logic              wr_en_q,   wr_en_d;
    logic              m2r_q,     m2r_d;
    logic [2:0]        op_q,      op_d;
    logic [4:0]        rd_q,      rd_d;
    logic              rw_q,      rw_d;
    logic              mis_q,     mis_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    // Decode of the incoming EX instruction
    logic              is_load;
    logic              is_store;
    logic              is_word;
    logic              is_half;
    logic              mis_hit;
    logic              sel_b;
    logic              sel_h;
    logic              sel_w;
    logic [ADDR_W-1:0] steer_data;
    logic [3:0]        steer_be;

    always_comb begin
        // A read+write combination is treated as a pure load.
        is_load  = ex_mem_read;
        is_store = ex_mem_write & ~ex_mem_read;
        is_word  = (ex_mem_op == OP_W);
        // Only the signed half op is a halfword store; lhu is load-only.
        is_half  = is_load ? ((ex_mem_op == OP_H) | (ex_mem_op == OP_HU))
                           : (ex_mem_op == OP_H);
        mis_hit  = (is_load | is_store)
                 & ((is_word & (|ex_alu_result[1:0]))
                  | (is_half & ex_alu_result[0]));
    end

    always_comb begin
        sel_b      = (ex_mem_op == OP_B) | (ex_mem_op == OP_BU);
        sel_h      = (ex_mem_op == OP_H) | (ex_mem_op == OP_HU);
        sel_w      = ~sel_b & ~sel_h;
        steer_data = ex_store_data;
        steer_be   = 4'b0000;
        if (is_store & ~mis_hit) begin
            unique case (1'b1)
                sel_b: begin
                    steer_data = {NBYTES{ex_store_data[7:0]}};
                    steer_be   = 4'b0001 << ex_alu_result[1:0];
                end
                sel_h: begin
                    steer_data = {(NBYTES/2){ex_store_data[15:0]}};
                    steer_be   = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                end
                sel_w: begin
                    steer_data = ex_store_data;
                    steer_be   = 4'b1111;
                end
                default: begin
                    steer_data = ex_store_data;
                    steer_be   = 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        m2r_d   = m2r_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        if (flush | (~stall & ~ex_valid)) begin
            // Kill: control bits drop, data fields keep their values.
            valid_d = 1'b0;
            rd_en_d = 1'b0;
            wr_en_d = 1'b0;
            m2r_d   = 1'b0;
            rw_d    = 1'b0;
            mis_d   = 1'b0;
            be_d    = 4'b0000;
        end else if (!stall) begin
            valid_d = 1'b1;
            addr_d  = ex_alu_result;
            wdata_d = steer_data;
            be_d    = steer_be;
            op_d    = ex_mem_op;
            rd_d    = ex_rd;
            mis_d   = mis_hit;
            rd_en_d = is_load & ~mis_hit;
            wr_en_d = is_store & ~mis_hit;
            m2r_d   = ex_mem_to_reg & ~mis_hit;
            rw_d    = ex_reg_write & ~mis_hit & (ex_rd != 5'd0);
            if (mis_hit && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            m2r_q   <= 1'b0;
            op_q    <= 3'b000;
            rd_q    <= 5'd0;
            rw_q    <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            m2r_q   <= m2r_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_byte_en    = be_q;
    assign mem_read       = rd_en_q;
    assign mem_write      = wr_en_q;
    assign mem_to_reg     = m2r_q;
    assign mem_op         = op_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = rw_q;
    assign misalign       = mis_q;
    assign misalign_cnt   = cnt_q;

    // Loads are not forwardable from MEM; their data is not yet available.
    assign fwd_valid = valid_q & rw_q & ~rd_en_q;
    assign fwd_rd    = rd_q;
    assign fwd_data  = addr_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed steps plus random
// traffic compared against a transaction-level reference model.

module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic [2:0]  ex_mem_op;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_en;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [2:0]  mem_op;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        misalign;
    logic [7:0]  misalign_cnt;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_reg #(.ADDR_W(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_op(ex_mem_op), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_byte_en(mem_byte_en),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .mem_op(mem_op), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .misalign(misalign),
        .misalign_cnt(misalign_cnt), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    // Expected architectural contents of the MEM stage
    typedef struct {
        bit          valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          rd_en;
        bit          wr_en;
        bit          m2r;
        logic [2:0]  op;
        logic [4:0]  rd;
        bit          rw;
        bit          mis;
        int          cnt;
    } exp_t;

    exp_t m;

    function automatic exp_t model_reset();
        exp_t z;
        z.valid = 0; z.addr = '0; z.wdata = '0; z.be = '0;
        z.rd_en = 0; z.wr_en = 0; z.m2r = 0; z.op = '0;
        z.rd = '0; z.rw = 0; z.mis = 0; z.cnt = 0;
        return z;
    endfunction

    // Access size in bytes for a MEMop
    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd1, 3'd3: return 1;
            3'd2, 3'd4: return 2;
            default:    return 4;
        endcase
    endfunction

    // One clock edge of the EX/MEM stage, from the current inputs
    function automatic void model_edge();
        int sz;
        int lane;
        bit acc;
        bit bad;
        bit st;
        if (flush || (!stall && !ex_valid)) begin
            m.valid = 0; m.rd_en = 0; m.wr_en = 0; m.m2r = 0;
            m.rw = 0; m.mis = 0; m.be = 4'b0000;
        end else if (!stall) begin
            sz   = op_size(ex_mem_op);
            lane = int'(ex_alu_result % 4);
            acc  = ex_mem_read || ex_mem_write;
            bad  = acc && (lane % sz != 0);
            st   = ex_mem_write && !ex_mem_read && !bad;
            m.valid = 1;
            m.addr  = ex_alu_result;
            m.op    = ex_mem_op;
            m.rd    = ex_rd;
            m.mis   = bad;
            m.rd_en = ex_mem_read && !bad;
            m.wr_en = st;
            m.m2r   = ex_mem_to_reg && !bad;
            m.rw    = ex_reg_write && !bad && (ex_rd != 0);
            m.wdata = ex_store_data;
            m.be    = 4'b0000;
            if (st) begin
                if (sz == 1) begin
                    m.wdata = 32'(ex_store_data[7:0]) * 32'h01010101;
                    m.be    = 4'((1 << lane));
                end else if (sz == 2) begin
                    m.wdata = 32'(ex_store_data[15:0]) * 32'h00010001;
                    m.be    = 4'((3 << lane));
                end else begin
                    m.be    = 4'b1111;
                end
            end
            if (bad && m.cnt < 255) m.cnt++;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit fv;
        fv = m.valid && m.rw && !m.rd_en;
        chk({tag, ".valid"}, 32'(mem_valid), 32'(m.valid));
        chk({tag, ".addr"}, mem_address, m.addr);
        chk({tag, ".wdata"}, mem_write_data, m.wdata);
        chk({tag, ".be"}, 32'(mem_byte_en), 32'(m.be));
        chk({tag, ".read"}, 32'(mem_read), 32'(m.rd_en));
        chk({tag, ".write"}, 32'(mem_write), 32'(m.wr_en));
        chk({tag, ".to_reg"}, 32'(mem_to_reg), 32'(m.m2r));
        chk({tag, ".op"}, 32'(mem_op), 32'(m.op));
        chk({tag, ".rd"}, 32'(mem_rd), 32'(m.rd));
        chk({tag, ".reg_write"}, 32'(mem_reg_write), 32'(m.rw));
        chk({tag, ".misalign"}, 32'(misalign), 32'(m.mis));
        chk({tag, ".cnt"}, 32'(misalign_cnt), 32'(m.cnt));
        chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(fv));
        chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(m.rd));
        chk({tag, ".fwd_data"}, fwd_data, m.addr);
    endtask

    task automatic drive(input bit v, input logic [2:0] op,
                         input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] d, input bit rde,
                         input bit wre, input bit m2r, input bit rw);
        ex_valid      = v;
        ex_mem_op     = op;
        ex_rd         = rd;
        ex_alu_result = a;
        ex_store_data = d;
        ex_mem_read   = rde;
        ex_mem_write  = wre;
        ex_mem_to_reg = m2r;
        ex_reg_write  = rw;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive_random();
        bit rde;
        bit wre;
        logic [2:0] op;
        rde = ($urandom_range(0, 2) == 0);
        wre = ($urandom_range(0, 2) == 0);
        op  = (wre && !rde) ? 3'($urandom_range(0, 3))
                            : 3'($urandom_range(0, 4));
        drive($urandom_range(0, 3) != 0, op, 5'($urandom),
              $urandom, $urandom, rde, wre, 1'($urandom), 1'($urandom));
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(0, 3'd0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        m = model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // sb 0xA5 at 0x6
        drive(1, 3'd1, 5'd0, 32'h6, 32'h000000A5, 0, 1, 0, 0);
        step("sb");
        chk("sb_data", mem_write_data, 32'hA5A5A5A5);
        chk("sb_be", 32'(mem_byte_en), 32'b0100);

        // sh 0x1234 at 0x2
        drive(1, 3'd2, 5'd0, 32'h2, 32'h00001234, 0, 1, 0, 0);
        step("sh");
        chk("sh_data", mem_write_data, 32'h12341234);
        chk("sh_be", 32'(mem_byte_en), 32'b1100);

        // misaligned lw at 0x3
        drive(1, 3'd0, 5'd7, 32'h3, 32'h0, 1, 0, 1, 1);
        step("lw_mis");
        chk("lw_mis_flag", 32'(misalign), 32'd1);
        chk("lw_mis_cnt", 32'(misalign_cnt), 32'd1);

        // ALU op forwarding, rd=5 then rd=0, then a load
        drive(1, 3'd0, 5'd5, 32'hDEADBEEF, 32'h0, 0, 0, 0, 1);
        step("alu_rd5");
        chk("fwd_rd5", 32'(fwd_valid), 32'd1);
        chk("fwd_data5", fwd_data, 32'hDEADBEEF);
        drive(1, 3'd0, 5'd0, 32'hDEADBEEF, 32'h0, 0, 0, 0, 1);
        step("alu_rd0");
        chk("fwd_rd0", 32'(fwd_valid), 32'd0);
        drive(1, 3'd0, 5'd5, 32'h100, 32'h0, 1, 0, 1, 1);
        step("load_rd5");
        chk("fwd_load", 32'(fwd_valid), 32'd0);

        // Stall for three cycles while EX changes
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step("stall");
        end
        flush = 1'b1;
        step("stall_flush");
        chk("stall_flush_valid", 32'(mem_valid), 32'd0);
        stall = 1'b0;
        flush = 1'b0;

        // Bubble carrying a store request
        drive(0, 3'd0, 5'd3, 32'h40, 32'h55, 0, 1, 0, 0);
        step("bubble");
        chk("bubble_be", 32'(mem_byte_en), 32'd0);
        chk("bubble_cnt", 32'(misalign_cnt), 32'd1);

        // Asynchronous reset between edges
        drive(1, 3'd0, 5'd9, 32'h10, 32'hCAFEF00D, 0, 1, 0, 0);
        step("sw_pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        m = model_reset();
        check_all("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        // Counter saturation
        drive(1, 3'd0, 5'd4, 32'h3, 32'h0, 1, 0, 1, 1);
        for (int i = 0; i < 300; i++) begin
            step("sat");
        end
        chk("sat_cnt", 32'(misalign_cnt), 32'd255);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive_random();
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
